cpu_run_stat_ctrl: RTL and testbench
====================================

Name: cpu_run_stat_ctrl

Overview:
Run-control and statistics stage that sits directly upstream of the seven-segment display block. It gates the single-cycle MIPS core through continuous-run, single-step, pause and halt modes, and it accumulates the cycle and control-flow counters that the display shows on its 16-bit selections (Cycles, nocondition_num, condition_num, condition_success_num). All outputs are registered, so the display samples stable values.

Parameters:
CNT_W, 16, width of every statistics counter; must match the display's 16-bit inputs.

Ports:
clk  in  1  core clock; all logic on posedge.
rst  in  1  synchronous reset, active-high.
go  in  1  debounced run/step button, level; only the rising edge is used.
step_mode  in  1  level switch: 1 = single-step, 0 = continuous run.
instr_valid  in  1  core retires an instruction this cycle.
is_jump  in  1  retired instruction is unconditional (j, jal, jr).
is_branch  in  1  retired instruction is conditional (beq, bne).
branch_taken  in  1  conditional branch resolved taken.
is_halt  in  1  retired instruction is the halt syscall.
cpu_en  out  1  clock-enable to the core's PC and register-file writes.
halted  out  1  core stopped by halt instruction.
Cycles  out  CNT_W  enabled-cycle count.
nocondition_num  out  CNT_W  unconditional jump count.
condition_num  out  CNT_W  conditional branch count.
condition_success_num  out  CNT_W  taken conditional branch count.

Behaviour:
- Reset (rst=1 at posedge): state IDLE, cpu_en=0, halted=0, all counters 0, go edge register 0. Reset overrides every other input in every state, including mid-run and mid-step.
- go_rise = go & ~go_q. go_q is registered every cycle, including during reset (it is cleared to 0).
- Event qualifier: ev = cpu_en & instr_valid. Events while cpu_en=0 are ignored.
- FSM states: IDLE, RUN, STEP, PAUSE, HALTED. cpu_en=1 only in RUN and STEP.
  - IDLE: on go_rise, go to STEP if step_mode=1, otherwise RUN.
  - RUN:
    - ev & is_halt: go to HALTED (halt has priority).
    - Otherwise, step_mode=1: go to PAUSE.
    - Otherwise stay in RUN.
  - STEP: lasts exactly one cycle. Go to HALTED if ev & is_halt, otherwise PAUSE.
  - PAUSE: on go_rise, go to STEP if step_mode=1, otherwise RUN.
  - HALTED: sticky until rst. go is ignored. halted=1.
- cpu_en and halted are registered, decoded from the next state, so cpu_en is high in the same cycle the FSM occupies RUN/STEP. Latency is one cycle from the go_rise sample edge to cpu_en=1.
- A single-step produces exactly one cpu_en=1 cycle per go press, regardless of how long go is held.
- Counters, each saturating at 2^CNT_W-1 (no wrap); increments are applied at the posedge:
  - Cycles increments when cpu_en=1.
  - nocondition_num increments on ev & is_jump.
  - condition_num increments on ev & is_branch.
  - condition_success_num increments on ev & is_branch & branch_taken.
- branch_taken without is_branch is ignored. is_jump and is_branch both high: both counters increment (no arbitration).
- The halt instruction's own cycle counts in Cycles. Its jump/branch flags count normally.
- Counters hold their values in IDLE, PAUSE and HALTED. They are cleared only by rst.

Decomposition:
- Shared package cpu_stat_pkg holds:
  - state enum (IDLE=0, RUN=1, STEP=2, PAUSE=3, HALTED=4, 3-bit);
  - CNT_W default constant.
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, q). Instantiated four times.
- FSM and edge detect live in the top module.

Test Plan:
1. Reset, then go pulse with step_mode=0 and instr_valid=1 for 10 cycles -> cpu_en=1 from the cycle after the go edge; Cycles=10.
2. step_mode=1; go held high for 5 cycles, three separate presses, instr_valid=1, is_branch=1, branch_taken alternating 1/0/1 -> exactly 3 cpu_en pulses; condition_num=3, condition_success_num=2, Cycles=3.
3. RUN with a jump every cycle, then is_halt at instruction 7 -> halted=1 and cpu_en=0 on the next cycle; nocondition_num=7; further go presses change nothing.
4. Force counters near max (run 65540 enabled cycles) -> Cycles stays at 0xFFFF, no wrap to 0.
5. Assert rst in the middle of STEP and mid-RUN -> next cycle cpu_en=0, halted=0, all counters 0, state IDLE.
6. cpu_en=0 (IDLE/PAUSE) with instr_valid=is_jump=is_branch=branch_taken=1 -> no counter changes; branch_taken=1 with is_branch=0 during RUN -> condition_success_num unchanged.

Source files
------------

// File: rtl/cpu_run_stat_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_stat_pkg
// Shared definitions for the run-control / statistics stage that feeds the
// seven-segment display: the run-control state encoding and the default
// statistics counter width (the display's selections are 16 bits wide).
// ---------------------------------------------------------------------------
package cpu_stat_pkg;

    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        PAUSE  = 3'd3,
        HALTED = 3'd4
    } run_state_e;

endpackage

// File: rtl/cpu_run_stat_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_run_stat_if
// Bundles the user controls, the core's retire-time flags and the
// controller's outputs (core enable, halt flag, statistics counters).
//   master : drives go/step_mode and the retire flags, observes the outputs
//   slave  : the run-control stage itself
// ---------------------------------------------------------------------------
interface cpu_run_stat_if
    import cpu_stat_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) ();

    logic             go;
    logic             step_mode;
    logic             instr_valid;
    logic             is_jump;
    logic             is_branch;
    logic             branch_taken;
    logic             is_halt;
    logic             cpu_en;
    logic             halted;
    logic [CNT_W-1:0] Cycles;
    logic [CNT_W-1:0] nocondition_num;
    logic [CNT_W-1:0] condition_num;
    logic [CNT_W-1:0] condition_success_num;

    modport master (
        output go, step_mode, instr_valid, is_jump, is_branch, branch_taken, is_halt,
        input  cpu_en, halted, Cycles, nocondition_num, condition_num, condition_success_num
    );

    modport slave (
        input  go, step_mode, instr_valid, is_jump, is_branch, branch_taken, is_halt,
        output cpu_en, halted, Cycles, nocondition_num, condition_num, condition_success_num
    );

endinterface

// File: rtl/cpu_run_stat_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// W-bit up-counter that sticks at its all-ones maximum instead of wrapping.
//   clk : clock (posedge)
//   rst : synchronous active-high clear
//   inc : count enable for this cycle
//   q   : registered count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        if (&v)
            return v;
        else
            return v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (inc)
            q <= sat_inc(q);
    end

endmodule

// File: rtl/cpu_run_stat_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_stat_ctrl
// Run-control and statistics stage upstream of the seven-segment display.
// Gates the single-cycle core through continuous run, single step, pause and
// halt, and counts enabled cycles plus unconditional / conditional / taken
// control-flow instructions. All outputs are registered.
//   clk : core clock (posedge)
//   rst : synchronous active-high reset
//   bus : cpu_run_stat_if.slave
//         in : go, step_mode, instr_valid, is_jump, is_branch, branch_taken,
//              is_halt
//         out: cpu_en, halted, Cycles, nocondition_num, condition_num,
//              condition_success_num
// ---------------------------------------------------------------------------
module cpu_run_stat_ctrl
    import cpu_stat_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    cpu_run_stat_if.slave   bus
);

    logic             go_q;
    logic             go_rise;
    logic             ev;
    logic             halt_ev;
    run_state_e       state;
    run_state_e       state_nxt;
    logic             cpu_en;
    logic             halted;
    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] jump_q;
    logic [CNT_W-1:0] branch_q;
    logic [CNT_W-1:0] taken_q;

    assign go_rise = bus.go & ~go_q;
    // Retire flags only mean something while the core is actually enabled.
    assign ev      = cpu_en & bus.instr_valid;
    assign halt_ev = ev & bus.is_halt;

    function automatic run_state_e next_state(input run_state_e s,
                                              input logic       rise,
                                              input logic       single,
                                              input logic       hlt);
        run_state_e n;
        n = s;
        unique case (s)
            IDLE, PAUSE: if (rise) n = single ? STEP : RUN;
            // Halt wins over a simultaneous switch to single-step.
            RUN:         if (hlt) n = HALTED; else if (single) n = PAUSE;
            STEP:        n = hlt ? HALTED : PAUSE;
            HALTED:      n = HALTED;
            default:     n = IDLE;
        endcase
        return n;
    endfunction

    assign state_nxt = next_state(state, go_rise, bus.step_mode, halt_ev);

    // Outputs are decoded from the next state so cpu_en is high during the
    // very cycle the FSM sits in RUN/STEP.
    always_ff @(posedge clk) begin
        if (rst) begin
            go_q   <= 1'b0;
            state  <= IDLE;
            cpu_en <= 1'b0;
            halted <= 1'b0;
        end else begin
            go_q   <= bus.go;
            state  <= state_nxt;
            cpu_en <= (state_nxt == RUN) || (state_nxt == STEP);
            halted <= (state_nxt == HALTED);
        end
    end

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk (clk),
        .rst (rst),
        .inc (cpu_en),
        .q   (cycles_q)
    );

    sat_counter #(.W(CNT_W)) u_jump (
        .clk (clk),
        .rst (rst),
        .inc (ev & bus.is_jump),
        .q   (jump_q)
    );

    sat_counter #(.W(CNT_W)) u_branch (
        .clk (clk),
        .rst (rst),
        .inc (ev & bus.is_branch),
        .q   (branch_q)
    );

    sat_counter #(.W(CNT_W)) u_taken (
        .clk (clk),
        .rst (rst),
        .inc (ev & bus.is_branch & bus.branch_taken),
        .q   (taken_q)
    );

    assign bus.cpu_en                = cpu_en;
    assign bus.halted                = halted;
    assign bus.Cycles                = cycles_q;
    assign bus.nocondition_num       = jump_q;
    assign bus.condition_num         = branch_q;
    assign bus.condition_success_num = taken_q;

endmodule

// File: tb/tb_cpu_run_stat_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_stat_ctrl
// Self-checking bench: directed scenarios plus a randomized phase, compared
// every cycle against a behavioural model of the run-control rules.
// ---------------------------------------------------------------------------
module tb_cpu_run_stat_ctrl;

    localparam int CNT_W = 16;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cpu_run_stat_if #(.CNT_W(CNT_W)) bus ();

    cpu_run_stat_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Behavioural model: whether the core is enabled this cycle, whether the
    // current enable belongs to a continuous run, whether it has halted, and
    // plain integer counts clipped at the maximum.
    bit m_en, m_cont, m_halted, m_goq;
    int m_cyc, m_jmp, m_br, m_tk;
    bit m_rise, m_ev;

    function automatic int sat1(input int v);
        return (v < MAXV) ? v + 1 : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_en = 0; m_cont = 0; m_halted = 0; m_goq = 0;
            m_cyc = 0; m_jmp = 0; m_br = 0; m_tk = 0;
        end else begin
            m_rise = bus.go && !m_goq;
            m_ev   = m_en && bus.instr_valid;
            if (m_en)                                      m_cyc = sat1(m_cyc);
            if (m_ev && bus.is_jump)                       m_jmp = sat1(m_jmp);
            if (m_ev && bus.is_branch)                     m_br  = sat1(m_br);
            if (m_ev && bus.is_branch && bus.branch_taken) m_tk  = sat1(m_tk);
            if (!m_halted) begin
                if (m_ev && bus.is_halt) begin
                    m_halted = 1; m_en = 0;
                end else if (m_en) begin
                    // a single step always ends; a run ends when stepping is selected
                    if (!m_cont || bus.step_mode) m_en = 0;
                end else if (m_rise) begin
                    m_en = 1; m_cont = !bus.step_mode;
                end
            end
            m_goq = bus.go;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_en",  32'(bus.cpu_en), 32'(m_en));
            chk("halted",  32'(bus.halted), 32'(m_halted));
            chk("Cycles",  32'(bus.Cycles), 32'(m_cyc));
            chk("nocond",  32'(bus.nocondition_num), 32'(m_jmp));
            chk("cond",    32'(bus.condition_num), 32'(m_br));
            chk("cond_ok", 32'(bus.condition_success_num), 32'(m_tk));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic flags(input bit v, input bit j, input bit b, input bit t, input bit h);
        bus.instr_valid = v; bus.is_jump = j; bus.is_branch = b;
        bus.branch_taken = t; bus.is_halt = h;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.go = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_en"},   32'(bus.cpu_en), 32'd0);
        chk({tag, "_halt"}, 32'(bus.halted), 32'd0);
        chk({tag, "_cyc"},  32'(bus.Cycles), 32'd0);
        chk({tag, "_jmp"},  32'(bus.nocondition_num), 32'd0);
        chk({tag, "_br"},   32'(bus.condition_num), 32'd0);
        chk({tag, "_tk"},   32'(bus.condition_success_num), 32'd0);
    endtask

    initial begin
        bus.go = 1'b0; bus.step_mode = 1'b0;
        flags(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        all_zero("reset");

        // 1: continuous run for exactly 10 enabled cycles
        bus.step_mode = 1'b0; flags(1, 0, 0, 0, 0);
        bus.go = 1'b1; tick(); bus.go = 1'b0;
        chk("t1_en_after_go", 32'(bus.cpu_en), 32'd1);
        repeat (9) tick();
        bus.step_mode = 1'b1; tick();
        chk("t1_cycles", 32'(bus.Cycles), 32'd10);
        chk("t1_paused", 32'(bus.cpu_en), 32'd0);

        // 2: three single steps with go held for 5 cycles each
        do_reset();
        bus.step_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            flags(1, 0, 1, (k != 1), 0);
            bus.go = 1'b1; repeat (5) tick();
            bus.go = 1'b0; repeat (2) tick();
        end
        chk("t2_cond",    32'(bus.condition_num), 32'd3);
        chk("t2_cond_ok", 32'(bus.condition_success_num), 32'd2);
        chk("t2_cycles",  32'(bus.Cycles), 32'd3);

        // 3: jumps every cycle, halt on the 7th instruction
        do_reset();
        bus.step_mode = 1'b0; flags(1, 1, 0, 0, 0);
        bus.go = 1'b1; tick(); bus.go = 1'b0;
        repeat (6) tick();
        bus.is_halt = 1'b1; tick(); bus.is_halt = 1'b0;
        chk("t3_halted", 32'(bus.halted), 32'd1);
        chk("t3_en",     32'(bus.cpu_en), 32'd0);
        chk("t3_nocond", 32'(bus.nocondition_num), 32'd7);
        repeat (3) begin bus.go = 1'b1; tick(); bus.go = 1'b0; tick(); end
        chk("t3_still_halted", 32'(bus.halted), 32'd1);
        chk("t3_cycles",       32'(bus.Cycles), 32'd7);

        // 4: saturation of the cycle counter
        do_reset();
        bus.step_mode = 1'b0; flags(0, 0, 0, 0, 0);
        bus.go = 1'b1; tick(); bus.go = 1'b0;
        repeat (65540) tick();
        chk("t4_sat", 32'(bus.Cycles), 32'h0000_FFFF);
        bus.step_mode = 1'b1; tick();

        // 5: reset mid-step and mid-run
        do_reset();
        bus.step_mode = 1'b0; flags(1, 1, 1, 1, 0);
        bus.go = 1'b1; tick(); bus.go = 1'b0;
        repeat (4) tick();
        bus.step_mode = 1'b1; tick(); tick();
        bus.go = 1'b1; tick();
        chk("t5_in_step", 32'(bus.cpu_en), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0; bus.go = 1'b0;
        all_zero("t5_step");
        bus.step_mode = 1'b0;
        bus.go = 1'b1; tick(); bus.go = 1'b0;
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        all_zero("t5_run");

        // 6: flags ignored while disabled; taken without branch ignored
        flags(1, 1, 1, 1, 1); repeat (5) tick();
        all_zero("t6_idle");
        flags(1, 0, 0, 1, 0); bus.step_mode = 1'b0;
        bus.go = 1'b1; tick(); bus.go = 1'b0;
        repeat (4) tick();
        bus.step_mode = 1'b1; tick();
        chk("t6_cycles",  32'(bus.Cycles), 32'd5);
        chk("t6_cond_ok", 32'(bus.condition_success_num), 32'd0);
        flags(1, 1, 1, 1, 1); repeat (5) tick();
        chk("t6_pause_jmp", 32'(bus.nocondition_num), 32'd0);
        chk("t6_pause_cyc", 32'(bus.Cycles), 32'd5);

        // randomized phase
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst           = ($urandom_range(0, 199) == 0);
            bus.go        = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) bus.step_mode = ~bus.step_mode;
            flags($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 59) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
